// File: rtl/fp_pkg.sv
// Shared floating-point constants and field layouts for the fp_mac result path.
// Holds binary32/binary16 field widths, exponent biases, and the canonical
// special encodings used by the fp32 -> fp16 narrowing converter.
package fp_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  localparam int FP32_BIAS = 127;
  localparam int FP16_BIAS = 15;
  // Rebias offset between the two formats (fp32 exponent 112 maps to fp16 exponent 0).
  localparam int EXP_ADJ   = FP32_BIAS - FP16_BIAS;

  // First fp32 exponent that no longer fits a finite fp16 exponent (112 + 31).
  localparam logic [FP32_EXP_W-1:0] EXP_OVF = FP32_EXP_W'(EXP_ADJ + 31);

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage

// File: rtl/fp32_to_fp16_rne.sv
// Combinational binary32 -> binary16 converter with round-to-nearest-even.
// Subnormal fp16 results are flushed to signed zero, and any fp32 NaN is
// returned as the canonical quiet NaN with its sign dropped.
// Ports:
//   y_i  fp32 input value
//   h_o  fp16 result
module fp32_to_fp16_rne
  import fp_pkg::*;
(
  input  logic [31:0] y_i,
  output logic [15:0] h_o
);

  fp32_t f;
  assign f = y_i;

  logic [FP16_EXP_W-1:0] e16;
  logic [FP16_MAN_W-1:0] mant;
  logic                  guard;
  logic                  sticky;
  logic                  lsb;
  logic                  rnd;
  logic [14:0]           mag;

  always_comb begin
    e16    = FP16_EXP_W'(f.exp - FP32_EXP_W'(EXP_ADJ));
    mant   = f.man[22:13];
    guard  = f.man[12];
    sticky = |f.man[11:0];
    lsb    = f.man[13];
    rnd    = guard & (sticky | lsb);
    // A mantissa carry ripples into the exponent; from e16=30 that lands
    // exactly on the infinity encoding 0x7C00, so no separate check is needed.
    mag    = {e16, mant} + 15'(rnd);
  end

  always_comb begin
    h_o = {f.sign, mag};
    if (f.exp == 8'hFF) begin
      h_o = (f.man != '0) ? FP16_QNAN : {f.sign, FP16_INF_MAG};
    end else if (f.exp >= EXP_OVF) begin
      h_o = {f.sign, FP16_INF_MAG};
    end else if (f.exp <= FP32_EXP_W'(EXP_ADJ)) begin
      h_o = {f.sign, 15'h0000};
    end
  end

endmodule

// File: rtl/mac_result_packer.sv
// Captures fp_mac results, narrows them to fp16 and queues them for the
// activation writer.
// fp_mac has no valid bit of its own, so a shift register re-times in_valid
// to the cycle in which mac_y holds the matching result.
// Ports:
//   CLK, RESETn  clock, async active-low reset
//   in_valid     operand set captured by fp_mac on this edge
//   mac_y        fp_mac output (binary32)
//   clr_ovf      clear the sticky overflow flag
//   out_data     FIFO head (binary16), zero while empty
//   out_valid    FIFO non-empty
//   out_ready    consumer takes out_data on this edge
//   fifo_count   current occupancy
//   overflow     sticky: a result was dropped because the FIFO was full
module mac_result_packer
  import fp_pkg::*;
#(
  parameter int MAC_LATENCY = 4,
  parameter int DEPTH       = 8
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     in_valid,
  input  logic [31:0]              mac_y,
  input  logic                     clr_ovf,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [MAC_LATENCY-1:0] vld_sr_q;
  logic                   tap;
  logic [15:0]            conv_h;
  logic                   stg_vld_q;
  logic [15:0]            stg_data_q;

  assign tap = vld_sr_q[MAC_LATENCY-1];

  fp32_to_fp16_rne u_conv (
    .y_i (mac_y),
    .h_o (conv_h)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      vld_sr_q   <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
    end else begin
      vld_sr_q[0] <= in_valid;
      for (int i = 1; i < MAC_LATENCY; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
      end
      stg_vld_q <= tap;
      if (tap) begin
        stg_data_q <= conv_h;
      end
    end
  end

  logic [15:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic        ovf_q, ovf_d;

  // Extra pointer MSB makes the difference range 0..DEPTH.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push  = stg_vld_q && (!full || pop);
  assign drop  = stg_vld_q && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= stg_data_q;
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_count = count;
  assign overflow   = ovf_q;

endmodule
